// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the responder FSM state type.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // RV32I load/store size/sign encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational RV32I lane steering for one memory access.
//
// Ports:
//   we          in   1   1 = store, 0 = load
//   funct3      in   3   access size/sign
//   addr_lo     in   2   byte offset within the word
//   wdata       in  32   store data, LSB-aligned
//   rdword      in  32   current contents of the addressed word
//   byte_en     out  4   byte lanes to write (all zero for loads and errors)
//   wdata_lane  out 32   store data replicated onto its lanes
//   rdata_ext   out 32   sign/zero extended load data (zero for stores/errors)
//   err         out  1   misaligned access or illegal funct3
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        err
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
        logic signed [7:0]  sb;
        logic signed [31:0] sw;
        sb = signed'(b);
        sw = 32'(sb);
        return is_signed ? 32'(sw) : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sh = signed'(h);
        sw = 32'(sh);
        return is_signed ? 32'(sw) : {16'd0, h};
    endfunction

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        shifted  = rdword >> {addr_lo, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = addr_lo[1] ? rdword[31:16] : rdword[15:0];

        byte_en    = 4'b0000;
        wdata_lane = 32'd0;
        rdata_ext  = 32'd0;
        err        = 1'b0;

        case (funct3)
            F3_B: begin
                if (we) begin
                    byte_en    = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end else begin
                    rdata_ext = ext_byte(sel_byte, 1'b1);
                end
            end
            F3_BU: begin
                // unsigned variants exist only for loads
                if (we) err = 1'b1;
                else    rdata_ext = ext_byte(sel_byte, 1'b0);
            end
            F3_H: begin
                if (addr_lo[0]) begin
                    err = 1'b1;
                end else if (we) begin
                    byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end else begin
                    rdata_ext = ext_half(sel_half, 1'b1);
                end
            end
            F3_HU: begin
                if (we || addr_lo[0]) err = 1'b1;
                else                  rdata_ext = ext_half(sel_half, 1'b0);
            end
            F3_W: begin
                if (addr_lo != 2'b00) begin
                    err = 1'b1;
                end else if (we) begin
                    byte_en    = 4'b1111;
                    wdata_lane = wdata;
                end else begin
                    rdata_ext = rdword;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory target for the RISC-V core: single-outstanding request/response
// handshake with WAIT_CYCLES programmable wait states and RV32I byte/halfword
// lane handling.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 4); addresses wrap
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake; ready only in IDLE with reset low
//   req_we, req_funct3  store/load select and RV32I size/sign
//   req_addr, req_wdata byte address and LSB-aligned store data
//   rsp_valid           one-cycle response strobe
//   rsp_rdata           extended load data (0 for stores and errors)
//   rsp_err             misaligned / illegal funct3, qualified by rsp_valid
//
// Optional feature (macro DMEM_PERF_CNT_EN):
//   load_count, store_count  successful load/store counters, wrap at 2^32
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         AW        = IDX_W + 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        accept;
    logic        commit;

    // Request fields latched at the accept edge
    logic          we_p0;
    logic [2:0]    funct3_p0;
    logic [AW-1:0] addr_p0;
    logic [31:0]   wdata_p0;

    // Access currently being committed
    logic          cur_we;
    logic [2:0]    cur_funct3;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [31:0]   rdword;

    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        acc_err;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the word index are ignored so addresses alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    assign accept = req_valid & req_ready;

    // With zero wait states the commit edge is the accept edge itself, so the
    // live request is used there; otherwise the latched copy is.
    always_comb begin
        if (state == IDLE) begin
            cur_we     = req_we;
            cur_funct3 = req_funct3;
            cur_addr   = req_addr[AW-1:0];
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = we_p0;
            cur_funct3 = funct3_p0;
            cur_addr   = addr_p0;
            cur_wdata  = wdata_p0;
        end
        rdword = mem[cur_addr[AW-1:2]];
    end

    dmem_lane_align u_lane_align (
        .we         (cur_we),
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rdword     (rdword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .err        (acc_err)
    );

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        commit        = 1'b0;
        req_ready     = (state == IDLE) && !reset;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control / response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            rsp_valid <= commit;
            if (commit) begin
                rsp_rdata <= rdata_ext;
                rsp_err   <= acc_err;
            end
        end
    end

    // Request capture (accept already excludes reset through req_ready)
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr[AW-1:0];
            wdata_p0  <= req_wdata;
        end
    end

    // Storage: lane-masked write on the commit edge; reset cancels it
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[cur_addr[AW-1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
        end else if (commit && !acc_err) begin
            if (cur_we) store_count <= store_count + 32'd1;
            else        load_count  <= load_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready,  rsp_valid,  rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] load_count, store_count, load_count0, store_count0;
`endif

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DMEM_PERF_CNT_EN
        ,
        .load_count (load_count),
        .store_count(store_count)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready0),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid0),
        .rsp_rdata  (rsp_rdata0),
        .rsp_err    (rsp_err0)
`ifdef DMEM_PERF_CNT_EN
        ,
        .load_count (load_count0),
        .store_count(store_count0)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    int          r_lat0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait (bounded) at a falling edge until both responders are idle
    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(req_ready && req_ready0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'(req_ready & req_ready0), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        wait_idle();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat  = 0;
        r_lat0 = 0;
        r_data = 32'hx;
        r_err  = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid0 && r_lat0 == 0) r_lat0 = c;
            if (rsp_valid) begin
                r_lat  = c;
                r_data = rsp_rdata;
                r_err  = rsp_err;
                break;
            end
        end
        if (r_lat == 0) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("rsp_pulse_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic req_chk(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_data, input logic exp_err);
        do_req(we, f3, addr, wd);
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_err"}, 32'(r_err), 32'(exp_err));
    endtask

    logic [4:0] held_ready_exp;
    logic [4:0] held_valid_exp;
    logic       seen_rsp;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata",  rsp_rdata,      32'd0);
        check("rst_rsp_err",    32'(rsp_err),   32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Store, then whole-word and sub-word loads
        req_chk("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check("lat_wait2", 32'(r_lat), 32'd3);
        check("lat_wait0", 32'(r_lat0), 32'd1);
        req_chk("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        req_chk("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        req_chk("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        req_chk("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        req_chk("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
        check("lat_load", 32'(r_lat), 32'd3);

        // Byte store touches only lane 1
        req_chk("sb_11",    1'b1, 3'b000, 32'h11, 32'h12345655, 32'h0, 1'b0);
        req_chk("lw_10_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

        // req_valid held high across two transactions
        held_ready_exp = 5'b01000;   // bit k-1 = expected req_ready at falling edge k
        held_valid_exp = 5'b00100;
        wait_idle();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("held_ready", 32'(req_ready), 32'(held_ready_exp[k-1]));
            check("held_rsp_valid", 32'(rsp_valid), 32'(held_valid_exp[k-1]));
            if (k == 3) check("held_rdata", rsp_rdata, 32'hDEAD55EF);
        end
        req_valid = 1'b0;

        // Error cases
        req_chk("sw_20",    1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        req_chk("sh_21",    1'b1, 3'b001, 32'h21, 32'h00001234, 32'h0, 1'b1);
        req_chk("lw_20",    1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
        req_chk("lw_22",    1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
        check("lat_err", 32'(r_lat), 32'd3);
        req_chk("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        req_chk("st_f3_011", 1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        req_chk("lw_20_chk", 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

        // Address wrap: 0x100 aliases word 0
        req_chk("sw_100", 1'b1, 3'b010, 32'h100, 32'h0BADCAFE, 32'h0, 1'b0);
        req_chk("lw_000", 1'b0, 3'b010, 32'h000, 32'h0, 32'h0BADCAFE, 1'b0);

        req_chk("sw_40", 1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0);
`ifdef DMEM_PERF_CNT_EN
        check("load_count_pre",  load_count,  32'd11);
        check("store_count_pre", store_count, 32'd5);
`endif

        // Reset pulse while the store is waiting: dropped, no response
        wait_idle();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen_rsp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen_rsp = seen_rsp | rsp_valid;
        end
        check("reset_no_rsp", 32'(seen_rsp), 32'd0);
`ifdef DMEM_PERF_CNT_EN
        check("load_count_rst",  load_count,  32'd0);
        check("store_count_rst", store_count, 32'd0);
`endif
        req_chk("lw_40_after_rst", 1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1'b0);
`ifdef DMEM_PERF_CNT_EN
        check("load_count_post", load_count, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
